// File: rtl/ldtu_baseline_detect.sv
// LiTe-DTU baseline/signal classifier: 2-stage aligned delay of sample, flag and orbit.
// Optional hold extension of signal classification enabled by LDTU_BASELINE_HOLD_EN.
module ldtu_baseline_detect #(
  parameter int unsigned NB_BASE = 6,
  parameter int unsigned HOLD    = 2
) (
  input  logic        CLK_,
  input  logic        reset_,
  input  logic        fallback_,
  input  logic        Orbit_in,
  input  logic [12:0] DATA_in,
  output logic [12:0] DATA_out,
  output logic        baseline_flag,
  output logic        Orbit,
  output logic        hold_active
);

  localparam logic [2:0] HoldInit = 3'(HOLD);

  logic [12:0] d1;
  logic        o1;
  logic        is_base;

  // Gain bit set always means signal, whatever the ADC code.
  assign is_base = ~d1[12] && (d1[11:NB_BASE] == '0);

  always_ff @(posedge CLK_ or negedge reset_) begin
    if (!reset_) begin
      d1       <= '0;
      o1       <= 1'b0;
      DATA_out <= '0;
      Orbit    <= 1'b0;
    end else begin
      d1       <= DATA_in;
      o1       <= Orbit_in;
      DATA_out <= d1;
      Orbit    <= o1;
    end
  end

`ifdef LDTU_BASELINE_HOLD_EN
  logic [2:0] hold_cnt;

  // Fallback has priority over a signal sample, so the counter is not loaded then.
  always_ff @(posedge CLK_ or negedge reset_) begin
    if (!reset_) begin
      baseline_flag <= 1'b0;
      hold_cnt      <= '0;
    end else if (fallback_) begin
      baseline_flag <= 1'b0;
      hold_cnt      <= '0;
    end else if (!is_base) begin
      baseline_flag <= 1'b0;
      hold_cnt      <= HoldInit;
    end else if (hold_cnt != '0) begin
      baseline_flag <= 1'b0;
      hold_cnt      <= hold_cnt - 3'd1;
    end else begin
      baseline_flag <= 1'b1;
    end
  end

  assign hold_active = (hold_cnt != '0);
`else
  logic unused_hold;
  assign unused_hold = ^HoldInit;

  always_ff @(posedge CLK_ or negedge reset_) begin
    if (!reset_) begin
      baseline_flag <= 1'b0;
    end else begin
      baseline_flag <= is_base && !fallback_;
    end
  end

  assign hold_active = 1'b0;
`endif

endmodule

// File: tb/tb_ldtu_baseline_detect.sv
// Directed self-checking bench for ldtu_baseline_detect (default HOLD=2).
// Expected values follow the build: hold extension only when LDTU_BASELINE_HOLD_EN is set.
module tb_ldtu_baseline_detect;

`ifdef LDTU_BASELINE_HOLD_EN
  localparam bit HoldOn = 1'b1;
`else
  localparam bit HoldOn = 1'b0;
`endif

  logic        CLK_ = 1'b0;
  logic        reset_;
  logic        fallback_;
  logic        Orbit_in;
  logic [12:0] DATA_in;
  logic [12:0] DATA_out;
  logic        baseline_flag;
  logic        Orbit;
  logic        hold_active;

  int n_vec = 0;
  int n_err = 0;
  int step_no = 0;

  always #5 CLK_ = ~CLK_;

  ldtu_baseline_detect dut (
    .CLK_          (CLK_),
    .reset_        (reset_),
    .fallback_     (fallback_),
    .Orbit_in      (Orbit_in),
    .DATA_in       (DATA_in),
    .DATA_out      (DATA_out),
    .baseline_flag (baseline_flag),
    .Orbit         (Orbit),
    .hold_active   (hold_active)
  );

  task automatic chk(input string tag, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    assert (act === exp)
    else begin
      n_err++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, act, exp);
    end
  endtask

  task automatic chk_all(input logic [12:0] ed, input logic ef, input logic eo, input logic eh);
    chk("data_out", DATA_out, ed);
    chk("baseline_flag", {12'd0, baseline_flag}, {12'd0, ef});
    chk("orbit", {12'd0, Orbit}, {12'd0, eo});
    chk("hold_active", {12'd0, hold_active}, {12'd0, eh});
  endtask

  // At a falling edge: check outputs (sample from two steps earlier), then drive the next input.
  task automatic step(input logic [12:0] d, input logic o, input logic fb, input logic ck,
                      input logic [12:0] ed, input logic ef, input logic eo, input logic eh);
    @(negedge CLK_);
    step_no++;
    if (ck) chk_all(ed, ef, eo, eh);
    DATA_in   = d;
    Orbit_in  = o;
    fallback_ = fb;
  endtask

  initial begin
    reset_    = 1'b0;
    fallback_ = 1'b0;
    Orbit_in  = 1'b1;
    DATA_in   = 13'h1ABC;
    repeat (3) @(posedge CLK_);
    #1;
    chk_all(13'h000, 1'b0, 1'b0, 1'b0);

    @(negedge CLK_);
    reset_   = 1'b1;
    Orbit_in = 1'b0;
    DATA_in  = 13'h005;
    // Post-reset sample and threshold boundary
    step(13'h000,  0, 0, 0, 13'h000, 0, 0, 0);
    step(13'h03F,  0, 0, 1, 13'h005, 1, 0, 0);
    step(13'h040,  0, 0, 1, 13'h000, 1, 0, 0);
    step(13'h1000, 0, 0, 1, 13'h03F, 1, 0, 0);
    step(13'h000,  0, 0, 1, 13'h040, 0, 0, HoldOn);
    // Hold extension: one signal then six baseline samples
    step(13'h0800, 0, 0, 1, 13'h1000, 0, 0, HoldOn);
    step(13'h010,  0, 0, 1, 13'h000, !HoldOn, 0, HoldOn);
    step(13'h010,  0, 0, 1, 13'h0800, 0, 0, HoldOn);
    step(13'h010,  0, 0, 1, 13'h010, !HoldOn, 0, HoldOn);
    step(13'h010,  0, 0, 1, 13'h010, !HoldOn, 0, 0);
    step(13'h010,  0, 0, 1, 13'h010, 1, 0, 0);
    step(13'h010,  0, 0, 1, 13'h010, 1, 0, 0);
    // Hold reload: sig, base, sig, base, base, base
    step(13'h0100, 0, 0, 1, 13'h010, 1, 0, 0);
    step(13'h001,  0, 0, 1, 13'h010, 1, 0, 0);
    step(13'h0100, 0, 0, 1, 13'h0100, 0, 0, HoldOn);
    step(13'h002,  0, 0, 1, 13'h001, !HoldOn, 0, HoldOn);
    step(13'h003,  0, 0, 1, 13'h0100, 0, 0, HoldOn);
    step(13'h004,  0, 0, 1, 13'h002, !HoldOn, 0, HoldOn);
    step(13'h005,  0, 0, 1, 13'h003, !HoldOn, 0, 0);
    step(13'h006,  0, 0, 1, 13'h004, 1, 0, 0);
    // Fallback for three S2 edges; last forced sample is a signal that must not load the counter
    step(13'h007,  0, 1, 1, 13'h005, 1, 0, 0);
    step(13'h0200, 0, 1, 1, 13'h006, 0, 0, 0);
    step(13'h009,  0, 1, 1, 13'h007, 0, 0, 0);
    step(13'h00A,  0, 0, 1, 13'h0200, 0, 0, 0);
    step(13'h00B,  0, 0, 1, 13'h009, 1, 0, 0);
    // Orbit alignment
    step(13'h0ABC, 1, 0, 1, 13'h00A, 1, 0, 0);
    step(13'h00C,  0, 0, 1, 13'h00B, 1, 0, 0);
    step(13'h00D,  0, 0, 1, 13'h0ABC, 0, 1, HoldOn);

    // Asynchronous reset in the middle of a hold, checked before the next rising edge
    #2;
    reset_ = 1'b0;
    #1;
    step_no++;
    chk_all(13'h000, 1'b0, 1'b0, 1'b0);

    @(negedge CLK_);
    reset_  = 1'b1;
    DATA_in = 13'h005;
    step(13'h006,  0, 0, 0, 13'h000, 0, 0, 0);
    step(13'h007,  0, 0, 1, 13'h005, 1, 0, 0);
    step(13'h008,  0, 0, 1, 13'h006, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
